bnn_param_loader: RTL and testbench
===================================

// Module: bnn_param_loader
// PURPOSE
// Host-side driver for the tiny BNN core's pin protocol. It serialises a parameter image
// into the core's param chain while holding setup high, and packs the bits that shift out
// of the chain tail into readback bytes. In inference it splits an input byte into the two
// nibble writes and captures the 8-bit result. It sits between a byte-stream host port and
// the core's clk/setup/param_in/x_bank_hi/x pins, on the same clock.
// PARAMETERS
// CHAIN_BITS    96  total param-chain length in bits, >=1; not required to be a multiple of 8
// RESULT_DELAY  1   cycles from the high-nibble write edge to the bnn_y capture, 1..7
// PORTS
// clk            in   1  system clock, also the core's clock
// reset          in   1  synchronous, active-high
// load_start     in   1  1-cycle pulse: begin a CHAIN_BITS load; ignored unless IDLE
// load_busy      out  1  high from the cycle after an accepted load_start until load done
// p_data         in   8  parameter byte, shifted LSB first
// p_valid        in   1  p_data valid
// p_ready        out  1  byte accepted on a cycle where p_valid&&p_ready
// rb_data        out  8  readback byte (old chain contents, first-out bit in bit 0)
// rb_valid       out  1  1-cycle pulse; no backpressure
// x_data         in   8  inference input; [3:0] is the low bank, [7:4] the high bank
// x_valid        in   1  x_data valid
// x_ready        out  1  high only in IDLE
// y_data         out  8  captured core output; holds its value until the next capture
// y_valid        out  1  1-cycle pulse when y_data updates
// bnn_setup      out  1  core setup pin (registered)
// bnn_param_in   out  1  core param_in pin (registered)
// bnn_x_bank_hi  out  1  core bank select (registered)
// bnn_x          out  4  core nibble input (registered)
// bnn_y          in   8  core outputs; bnn_y[7] carries the chain tail while setup=1
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, bit/byte counters cleared. A partial load is abandoned
//   and the chain contents become undefined, so the host must reload.
// - States: IDLE, LOAD, STALL, X_LO, X_HI, WAIT.
// - IDLE: p_ready=0 and x_ready=1. load_start takes priority over x_valid in the same cycle.
//   - load_start -> LOAD, bit_cnt=0.
//   - x_valid -> X_LO, latching x_data.
// - LOAD: p_ready=1 whenever the 8-bit shift register is empty.
//   - Each cycle with a bit available: bnn_setup=1 and bnn_param_in=next bit.
//   - On that same edge, bnn_y[7] is shifted into the readback register.
//   - After 8 captured bits, or the last bit, rb_valid pulses.
//   - A short final byte is right-aligned in rb_data with the upper bits 0.
//   - Unused high bits of the last p_data byte are discarded.
// - STALL: entered when the shift register empties before CHAIN_BITS bits and p_valid=0.
//   - bnn_setup=0, so the chain holds. Return to LOAD on the next p_valid.
//   - Zero-bubble requirement: a byte presented while the last bit is shifting does not
//     cause a STALL.
// - Load done after exactly CHAIN_BITS setup-high cycles:
//   - next cycle bnn_setup=0 and load_busy=0; state -> IDLE.
//   - load_start during a load is ignored.
//   - p_valid outside LOAD/STALL is not accepted.
// - X_LO: bnn_setup=0, bnn_x_bank_hi=0, bnn_x=x[3:0]. Next state X_HI.
// - X_HI: bnn_x_bank_hi=1, bnn_x=x[7:4]. Next state WAIT.
// - WAIT: count RESULT_DELAY cycles, then sample bnn_y into y_data, pulse y_valid, return to
//   IDLE.
//   - Latency: x_valid accepted at edge N -> y_valid high in cycle N+3+RESULT_DELAY.
// - The first setup-high cycle clears the core's input register, so inference results from
//   before a load are stale after it.
// TESTING
// - Reset, then idle 5 cycles -> all outputs 0, x_ready=1, load_busy=0.
// - CHAIN_BITS=96, stream 12 bytes 0xA5 back to back, core preloaded with 0x3C pattern:
//   - 96 setup cycles with no gap; param_in follows 1,0,1,0,0,1,0,1...
//   - 12 rb_valid pulses, each 0x3C; load_busy falls after bit 96.
// - Hold p_valid low for 4 cycles after byte 3 -> bnn_setup low exactly 4 cycles, no bit lost
//   or duplicated, rb bytes still 0x3C.
// - CHAIN_BITS=12, bytes 0xFF,0xFF -> 12 setup cycles; second rb byte right-aligned,
//   bits[7:4]=0.
// - x_data=0x7E after load, stub bnn_y=0x81 -> bnn_x 0xE then 0x7 with bank_hi 0 then 1;
//   y_data=0x81 at N+4.
// - Assert reset mid-load at bit 40 -> bnn_setup=0 next cycle, IDLE; a reload of 96 bits
//   completes correctly.

Source files
------------

// File: rtl/bnn_param_loader_if.sv
// Host-side byte-stream port of the BNN parameter loader: param load, readback and inference.
interface bnn_param_loader_if;
    logic       load_start;
    logic       load_busy;
    logic [7:0] p_data;
    logic       p_valid;
    logic       p_ready;
    logic [7:0] rb_data;
    logic       rb_valid;
    logic [7:0] x_data;
    logic       x_valid;
    logic       x_ready;
    logic [7:0] y_data;
    logic       y_valid;

    modport master (
        output load_start, p_data, p_valid, x_data, x_valid,
        input  load_busy, p_ready, rb_data, rb_valid, x_ready, y_data, y_valid
    );

    modport slave (
        input  load_start, p_data, p_valid, x_data, x_valid,
        output load_busy, p_ready, rb_data, rb_valid, x_ready, y_data, y_valid
    );
endinterface

// File: rtl/bnn_param_loader.sv
// Drives the BNN core pins: serialises the param chain LSB first, packs the chain tail into readback bytes.
// Inference: y_valid 3+RESULT_DELAY cycles after x accept; p_ready stalls the chain, rb/y have no backpressure.
module bnn_param_loader #(
    parameter int CHAIN_BITS   = 96,
    parameter int RESULT_DELAY = 1
) (
    input  logic                clk,
    input  logic                reset,
    bnn_param_loader_if.slave   host,
    output logic                bnn_setup,
    output logic                bnn_param_in,
    output logic                bnn_x_bank_hi,
    output logic [3:0]          bnn_x,
    input  logic [7:0]          bnn_y
);
    localparam int CW = $clog2(CHAIN_BITS + 9) + 1;

    typedef enum logic [2:0] {IDLE, LOAD, STALL, X_LO, X_HI, WAIT} state_t;

    state_t          state;
    logic [7:0]      sr;
    logic [3:0]      sr_cnt;
    logic [CW-1:0]   bit_cnt;
    logic [6:0]      rb_sr;
    logic [3:0]      rb_cnt;
    logic [3:0]      x_hi;
    logic [2:0]      wait_cnt;

    logic            in_load;
    logic            accept;
    logic            shift;
    logic            last_cap;
    logic [7:0]      rb_next;
    logic [3:0]      rb_cnt_next;

    assign in_load     = (state == LOAD) || (state == STALL);
    // Ready while the last buffered bit is leaving, so back-to-back bytes never bubble.
    assign host.p_ready = in_load && (sr_cnt <= 4'd1)
                          && ((bit_cnt + CW'(sr_cnt)) < CW'(CHAIN_BITS));
    assign host.x_ready = (state == IDLE);
    assign accept      = host.p_valid && host.p_ready;
    assign shift       = in_load && (sr_cnt != 4'd0) && (bit_cnt < CW'(CHAIN_BITS));
    assign last_cap    = bnn_setup && (bit_cnt == CW'(CHAIN_BITS));
    assign rb_next     = {bnn_y[7], rb_sr};
    assign rb_cnt_next = rb_cnt + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            sr             <= '0;
            sr_cnt         <= '0;
            bit_cnt        <= '0;
            rb_sr          <= '0;
            rb_cnt         <= '0;
            x_hi           <= '0;
            wait_cnt       <= '0;
            host.load_busy <= 1'b0;
            host.rb_data   <= '0;
            host.rb_valid  <= 1'b0;
            host.y_data    <= '0;
            host.y_valid   <= 1'b0;
            bnn_setup      <= 1'b0;
            bnn_param_in   <= 1'b0;
            bnn_x_bank_hi  <= 1'b0;
            bnn_x          <= '0;
        end else begin
            host.rb_valid <= 1'b0;
            host.y_valid  <= 1'b0;

            // The core shifts on every edge that sees setup high; its old tail is on bnn_y[7].
            if (bnn_setup) begin
                if (rb_cnt_next == 4'd8 || last_cap) begin
                    host.rb_valid <= 1'b1;
                    host.rb_data  <= rb_next >> (4'd8 - rb_cnt_next);
                    rb_sr         <= '0;
                    rb_cnt        <= '0;
                end else begin
                    rb_sr  <= rb_next[7:1];
                    rb_cnt <= rb_cnt_next;
                end
            end

            case (state)
                IDLE: begin
                    bnn_setup <= 1'b0;
                    if (host.load_start) begin
                        state          <= LOAD;
                        host.load_busy <= 1'b1;
                        bit_cnt        <= '0;
                        sr_cnt         <= '0;
                    end else if (host.x_valid) begin
                        state         <= X_LO;
                        x_hi          <= host.x_data[7:4];
                        bnn_x_bank_hi <= 1'b0;
                        bnn_x         <= host.x_data[3:0];
                    end
                end
                LOAD, STALL: begin
                    bnn_setup <= shift;
                    if (shift) begin
                        bnn_param_in <= sr[0];
                        bit_cnt      <= bit_cnt + CW'(1);
                    end
                    if (accept) begin
                        sr     <= host.p_data;
                        sr_cnt <= 4'd8;
                    end else if (shift) begin
                        sr     <= sr >> 1;
                        sr_cnt <= sr_cnt - 4'd1;
                    end
                    if (last_cap) begin
                        state          <= IDLE;
                        host.load_busy <= 1'b0;
                    end else if (host.p_ready && !host.p_valid) begin
                        state <= STALL;
                    end else begin
                        state <= LOAD;
                    end
                end
                X_LO: begin
                    bnn_x_bank_hi <= 1'b1;
                    bnn_x         <= x_hi;
                    state         <= X_HI;
                end
                X_HI: begin
                    wait_cnt <= 3'd1;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == 3'(RESULT_DELAY)) begin
                        host.y_data  <= bnn_y;
                        host.y_valid <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bnn_param_loader.sv
// Directed bench: two loaders (96-bit and 12-bit chains) each driving a behavioural param-chain core.
module tb_bnn_param_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    bnn_param_loader_if a_if();
    bnn_param_loader_if b_if();

    logic       a_setup, a_pin, a_bhi, b_setup, b_pin, b_bhi;
    logic [3:0] a_x, b_x;
    logic [7:0] a_y, b_y, y_stub;

    bnn_param_loader #(.CHAIN_BITS(96), .RESULT_DELAY(1)) dut_a (
        .clk(clk), .reset(reset), .host(a_if),
        .bnn_setup(a_setup), .bnn_param_in(a_pin), .bnn_x_bank_hi(a_bhi),
        .bnn_x(a_x), .bnn_y(a_y)
    );

    bnn_param_loader #(.CHAIN_BITS(12), .RESULT_DELAY(1)) dut_b (
        .clk(clk), .reset(reset), .host(b_if),
        .bnn_setup(b_setup), .bnn_param_in(b_pin), .bnn_x_bank_hi(b_bhi),
        .bnn_x(b_x), .bnn_y(b_y)
    );

    // Core models: chain shifts in at bit 0 while setup is high, tail is the top bit.
    logic [95:0] a_chain, pre_a;
    logic [11:0] b_chain, pre_b;
    logic        do_pre;
    always @(posedge clk) begin
        if (do_pre) begin
            a_chain <= pre_a;
            b_chain <= pre_b;
        end else begin
            if (a_setup) a_chain <= {a_chain[94:0], a_pin};
            if (b_setup) b_chain <= {b_chain[10:0], b_pin};
        end
    end
    assign a_y = a_setup ? {a_chain[95], 7'd0} : y_stub;
    assign b_y = b_setup ? {b_chain[11], 7'd0} : y_stub;

    // Monitors record setup-high cycles, shifted bits and readback bytes.
    logic       mon_clr;
    int         a_cyc, a_hi, a_first, a_last, b_cyc, b_hi, b_first, b_last;
    logic       a_bits[$];
    logic       b_bits[$];
    logic [7:0] a_rb[$];
    logic [7:0] b_rb[$];
    always @(negedge clk) begin
        if (mon_clr) begin
            a_cyc = 0; a_hi = 0; a_first = -1; a_last = -1;
            b_cyc = 0; b_hi = 0; b_first = -1; b_last = -1;
            a_bits.delete(); b_bits.delete(); a_rb.delete(); b_rb.delete();
        end else begin
            if (a_setup) begin
                if (a_first < 0) a_first = a_cyc;
                a_last = a_cyc; a_hi++; a_bits.push_back(a_pin);
            end
            if (b_setup) begin
                if (b_first < 0) b_first = b_cyc;
                b_last = b_cyc; b_hi++; b_bits.push_back(b_pin);
            end
            if (a_if.rb_valid) a_rb.push_back(a_if.rb_data);
            if (b_if.rb_valid) b_rb.push_back(b_if.rb_data);
            a_cyc++; b_cyc++;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1; step(); mon_clr = 1'b0;
    endtask

    task automatic preload();
        do_pre = 1'b1; step(); do_pre = 1'b0;
    endtask

    // Host for the 96-bit loader: 12 bytes of b, optional 4-ready-cycle gap after gap_after
    // bytes, optional early exit once abort_bits setup-high cycles have been seen.
    task automatic a_load(input logic [7:0] b, input int gap_after, input int abort_bits,
                          output int to);
        int   sent, gap, n;
        logic fire, ingap;
        sent = 0; gap = 0; to = 0;
        clr_mon();
        a_if.load_start = 1'b1; step(); a_if.load_start = 1'b0;
        for (n = 0; n < 400; n++) begin
            if (abort_bits > 0 && a_hi >= abort_bits) break;
            if (!a_if.load_busy) break;
            ingap = (sent == gap_after) && (gap < 4);
            a_if.p_valid = (sent < 12) && !ingap;
            a_if.p_data  = b;
            if (ingap && a_if.p_ready) gap++;
            fire = a_if.p_valid && a_if.p_ready;
            step();
            if (fire) sent++;
        end
        a_if.p_valid = 1'b0;
        to = (n >= 400) ? 1 : 0;
    endtask

    task automatic chk_load(input string tag, input logic [7:0] b, input int span, input int to,
                            input logic rb_chk, input logic [7:0] rb_exp);
        int nbad, rbad;
        nbad = 0; rbad = 0;
        foreach (a_bits[i]) if (a_bits[i] !== b[i % 8]) nbad++;
        foreach (a_rb[i]) if (a_rb[i] !== rb_exp) rbad++;
        chk({tag, "_timeout"}, to, 0);
        chk({tag, "_setup_cycles"}, a_hi, 96);
        chk({tag, "_setup_span"}, a_last - a_first + 1, span);
        chk({tag, "_param_bits_bad"}, nbad, 0);
        chk({tag, "_rb_count"}, a_rb.size(), 12);
        if (rb_chk) chk({tag, "_rb_bytes_bad"}, rbad, 0);
        chk({tag, "_done_busy_setup"}, {a_if.load_busy, a_setup}, 0);
    endtask

    initial begin
        int         to, bsent, ones;
        logic [7:0] pat;
        logic [11:0] pb;
        logic       fire;

        reset = 1'b1; do_pre = 1'b0; mon_clr = 1'b0; y_stub = 8'h81;
        a_if.load_start = 0; a_if.p_data = 0; a_if.p_valid = 0; a_if.x_data = 0; a_if.x_valid = 0;
        b_if.load_start = 0; b_if.p_data = 0; b_if.p_valid = 0; b_if.x_data = 0; b_if.x_valid = 0;
        pat = 8'h3C;
        pb  = 12'hA3C;
        for (int i = 0; i < 96; i++) pre_a[95 - i] = pat[i % 8];
        for (int i = 0; i < 12; i++) pre_b[11 - i] = pb[i];

        repeat (3) step();
        reset = 1'b0;
        repeat (5) step();
        chk("reset_pins", {a_setup, a_pin, a_bhi, a_x}, 0);
        chk("reset_flags", {a_if.load_busy, a_if.p_ready, a_if.rb_valid, a_if.y_valid}, 0);
        chk("reset_data", {a_if.rb_data, a_if.y_data}, 0);
        chk("reset_x_ready", a_if.x_ready, 1);

        // Back-to-back stream: no gaps, old 0x3C pattern reads back.
        preload();
        a_load(8'hA5, -1, 0, to);
        chk_load("stream", 8'hA5, 96, to, 1'b1, 8'h3C);

        // Host gap of 4 ready cycles after byte 3 stretches setup by exactly 4 cycles.
        preload();
        a_load(8'h96, 3, 0, to);
        chk_load("stall", 8'h96, 100, to, 1'b1, 8'h3C);

        a_if.p_valid = 1'b1; a_if.p_data = 8'hFF;
        step();
        chk("idle_p_ready", a_if.p_ready, 0);
        chk("idle_busy", a_if.load_busy, 0);
        a_if.p_valid = 1'b0;

        // Reset at bit 40 abandons the load.
        a_load(8'h11, -1, 40, to);
        chk("abort_bits", a_hi, 40);
        reset = 1'b1; step(); reset = 1'b0;
        chk("abort_setup", a_setup, 0);
        chk("abort_state", {a_if.load_busy, a_if.x_ready}, 2'b01);

        a_load(8'h5A, -1, 0, to);
        chk_load("reload", 8'h5A, 96, to, 1'b0, 8'h00);

        // Inference: 0x7E -> nibble E then 7, result 0x81 three edges after the bank-hi cycle.
        a_if.x_data = 8'h7E; a_if.x_valid = 1'b1;
        chk("x_ready_idle", a_if.x_ready, 1);
        step(); a_if.x_valid = 1'b0;
        chk("x_lo", {a_bhi, a_x}, 5'h0E);
        chk("x_busy", a_if.x_ready, 0);
        step();
        chk("x_hi", {a_bhi, a_x, a_setup}, 6'b1_0111_0);
        step();
        chk("y_early", a_if.y_valid, 0);
        step();
        chk("y_pulse", {a_if.y_valid, a_if.y_data}, 9'h181);
        step();
        chk("y_hold", {a_if.y_valid, a_if.y_data, a_if.x_ready}, 10'h103);

        // Readback of the 0x5A reload proves it completed bit-exact.
        a_load(8'hA5, -1, 0, to);
        chk_load("verify", 8'hA5, 96, to, 1'b1, 8'h5A);

        // 12-bit chain with 0xFF,0xFF: short final readback byte is right-aligned.
        preload();
        clr_mon();
        b_if.load_start = 1'b1; step(); b_if.load_start = 1'b0;
        bsent = 0; to = 1;
        for (int n = 0; n < 100; n++) begin
            if (!b_if.load_busy) begin to = 0; break; end
            b_if.p_valid = 1'b1; b_if.p_data = 8'hFF;
            fire = b_if.p_ready;
            step();
            if (fire) bsent++;
        end
        b_if.p_valid = 1'b0;
        ones = 0;
        foreach (b_bits[i]) if (b_bits[i] === 1'b1) ones++;
        chk("short_timeout", to, 0);
        chk("short_bytes_taken", bsent, 2);
        chk("short_setup_cycles", b_hi, 12);
        chk("short_setup_span", b_last - b_first + 1, 12);
        chk("short_ones", ones, 12);
        chk("short_rb_count", b_rb.size(), 2);
        chk("short_rb0", b_rb[0], 8'h3C);
        chk("short_rb1", b_rb[1], 8'h0A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
